// File: rtl/eps_arbiter_pkg.sv
// Shared defaults, reset constants and FSM encoding for the eps arbiter.
package eps_arbiter_pkg;

  localparam int unsigned NChDefault     = 4;
  localparam int unsigned TimeoutDefault = 64;
  localparam logic [15:0] TargetReset    = 16'd4096;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Cyclic successor of a channel index among n channels.
  function automatic logic [2:0] next_ch(input logic [2:0] ch, input int unsigned n);
    logic [2:0] nxt;
    if (32'(ch) + 32'd1 >= n) nxt = 3'd0;
    else                      nxt = ch + 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first pending channel at or after the pointer, cyclic.
module rr_pick
  import eps_arbiter_pkg::*;
#(
  parameter int unsigned N_CH = NChDefault
) (
  input  logic [N_CH-1:0] pend_i,
  input  logic [2:0]      ptr_i,
  output logic [N_CH-1:0] grant_o,
  output logic [2:0]      idx_o,
  output logic            any_o
);

  // Scan N_CH positions starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned c;
    logic        found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      c = 32'(ptr_i) + i;
      if (c >= N_CH) c = c - N_CH;
      for (int unsigned j = 0; j < N_CH; j++) begin
        if (!found && (j == c) && pend_i[j]) begin
          grant_o[j] = 1'b1;
          idx_o      = 3'(j);
          found      = 1'b1;
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/eps_arbiter.sv
// Arbitrates per-channel |x|^2 samples onto one shared external eps calculator.
module eps_arbiter
  import eps_arbiter_pkg::*;
#(
  parameter int unsigned N_CH    = NChDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req_i,
  input  logic [16*N_CH-1:0]   abs2_i,
  input  logic                 cfg_we_i,
  input  logic [2:0]           cfg_ch_i,
  input  logic [15:0]          cfg_target_i,
  output logic [15:0]          calc_abs2_o,
  output logic [15:0]          calc_target_o,
  output logic                 calc_valid_o,
  input  logic signed [31:0]   calc_eps_i,
  input  logic                 calc_valid_i,
  output logic signed [31:0]   eps_o,
  output logic [2:0]           eps_ch_o,
  output logic                 eps_valid_o,
  output logic [N_CH-1:0]      ack_o,
  output logic                 busy_o,
  output logic [N_CH-1:0]      overrun_o,
  output logic                 timeout_o
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e                 state_q, state_d;
  logic [N_CH-1:0]        pending_q, pending_d;
  logic [N_CH-1:0][15:0]  sample_q, sample_d;
  logic [N_CH-1:0][15:0]  target_q, target_d;
  logic [N_CH-1:0]        overrun_q, overrun_d;
  logic                   timeout_q, timeout_d;
  logic [2:0]             ptr_q, ptr_d;
  logic [2:0]             gnt_q, gnt_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [15:0]            calc_abs2_q, calc_abs2_d;
  logic [15:0]            calc_target_q, calc_target_d;
  logic                   calc_valid_q, calc_valid_d;
  logic [N_CH-1:0]        ack_q, ack_d;
  logic signed [31:0]     eps_q, eps_d;
  logic [2:0]             eps_ch_q, eps_ch_d;
  logic                   eps_valid_q, eps_valid_d;
  logic                   busy_q, busy_d;

  logic [N_CH-1:0]        pick_grant;
  logic [2:0]             pick_idx;
  logic                   pick_any;
  logic                   granting;

  rr_pick #(
    .N_CH(N_CH)
  ) u_rr_pick (
    .pend_i (pending_q),
    .ptr_i  (ptr_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign granting = (state_q == StIdle) && pick_any;

  // Next-state: request capture, target config, and the issue/wait/done sequence.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    sample_d      = sample_q;
    target_d      = target_q;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    calc_abs2_d   = calc_abs2_q;
    calc_target_d = calc_target_q;
    calc_valid_d  = 1'b0;
    ack_d         = '0;
    eps_d         = eps_q;
    eps_ch_d      = eps_ch_q;
    eps_valid_d   = 1'b0;

    for (int k = 0; k < N_CH; k++) begin
      if (granting && pick_grant[k]) pending_d[k] = 1'b0;
      if (req_i[k]) begin
        // A re-request in the grant cycle is a fresh sample, not an overrun.
        if (pending_q[k] && !(granting && pick_grant[k])) overrun_d[k] = 1'b1;
        pending_d[k] = 1'b1;
        sample_d[k]  = abs2_i[16*k +: 16];
      end
      // Channel ids beyond N_CH never match and are dropped.
      if (cfg_we_i && (cfg_ch_i == 3'(k))) target_d[k] = cfg_target_i;
    end

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          for (int k = 0; k < N_CH; k++) begin
            if (pick_grant[k]) begin
              calc_abs2_d   = sample_q[k];
              calc_target_d = target_q[k];
            end
          end
          gnt_d        = pick_idx;
          calc_valid_d = 1'b1;
          ack_d        = pick_grant;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (calc_valid_i) begin
          eps_d       = calc_eps_i;
          eps_ch_d    = gnt_q;
          eps_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          ptr_d     = next_ch(gnt_q, N_CH);
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        ptr_d   = next_ch(gnt_q, N_CH);
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      sample_q      <= '0;
      target_q      <= {N_CH{TargetReset}};
      overrun_q     <= '0;
      timeout_q     <= 1'b0;
      ptr_q         <= '0;
      gnt_q         <= '0;
      cnt_q         <= '0;
      calc_abs2_q   <= '0;
      calc_target_q <= '0;
      calc_valid_q  <= 1'b0;
      ack_q         <= '0;
      eps_q         <= '0;
      eps_ch_q      <= '0;
      eps_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      sample_q      <= sample_d;
      target_q      <= target_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      calc_abs2_q   <= calc_abs2_d;
      calc_target_q <= calc_target_d;
      calc_valid_q  <= calc_valid_d;
      ack_q         <= ack_d;
      eps_q         <= eps_d;
      eps_ch_q      <= eps_ch_d;
      eps_valid_q   <= eps_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign calc_abs2_o   = calc_abs2_q;
  assign calc_target_o = calc_target_q;
  assign calc_valid_o  = calc_valid_q;
  assign eps_o         = eps_q;
  assign eps_ch_o      = eps_ch_q;
  assign eps_valid_o   = eps_valid_q;
  assign ack_o         = ack_q;
  assign busy_o        = busy_q;
  assign overrun_o     = overrun_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_eps_arbiter.sv
// Directed bench for eps_arbiter; the bench plays the external calculator.
module tb_eps_arbiter;

  localparam int unsigned NCh = 4;
  localparam int unsigned Tmo = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCh-1:0]      req_i;
  logic [16*NCh-1:0]   abs2_i;
  logic                cfg_we_i;
  logic [2:0]          cfg_ch_i;
  logic [15:0]         cfg_target_i;
  logic [15:0]         calc_abs2_o;
  logic [15:0]         calc_target_o;
  logic                calc_valid_o;
  logic signed [31:0]  calc_eps_i;
  logic                calc_valid_i;
  logic signed [31:0]  eps_o;
  logic [2:0]          eps_ch_o;
  logic                eps_valid_o;
  logic [NCh-1:0]      ack_o;
  logic                busy_o;
  logic [NCh-1:0]      overrun_o;
  logic                timeout_o;

  int errors = 0;
  int checks = 0;

  eps_arbiter #(
    .N_CH   (NCh),
    .TIMEOUT(Tmo)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .abs2_i       (abs2_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_ch_i     (cfg_ch_i),
    .cfg_target_i (cfg_target_i),
    .calc_abs2_o  (calc_abs2_o),
    .calc_target_o(calc_target_o),
    .calc_valid_o (calc_valid_o),
    .calc_eps_i   (calc_eps_i),
    .calc_valid_i (calc_valid_i),
    .eps_o        (eps_o),
    .eps_ch_o     (eps_ch_o),
    .eps_valid_o  (eps_valid_o),
    .ack_o        (ack_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    req_i        = '0;
    cfg_we_i     = 1'b0;
    calc_valid_i = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Bounded wait for the next issue cycle.
  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok) begin
        if (calc_valid_o) ok = 1'b1;
        else              step();
      end
    end
  endtask

  // Returns in the cycle where the routed result should be visible.
  task automatic respond(input logic [31:0] eps, input int delay);
    for (int i = 0; i < delay; i++) step();
    calc_eps_i   = eps;
    calc_valid_i = 1'b1;
    step();
    calc_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = '0; abs2_i = '0; cfg_we_i = 1'b0; cfg_ch_i = '0;
    cfg_target_i = '0; calc_eps_i = '0; calc_valid_i = 1'b0;
    step();
    step();
    checks++;
    if ({calc_abs2_o, calc_target_o, calc_valid_o, eps_o, eps_ch_o, eps_valid_o, ack_o,
         busy_o, overrun_o, timeout_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b ack=%b eps=%0d want all zero", busy_o, ack_o, eps_o);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy_o !== 1'b0 || calc_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b cv=%b want 0 0", busy_o, calc_valid_o);
    end
  endtask

  task automatic test_single();
    req_i = 4'b0001; abs2_i[15:0] = 16'd3176;
    step();
    req_i = '0;
    checks++;
    if (calc_valid_o !== 1'b0) begin
      errors++; $display("FAIL single_early got cv=%b want 0", calc_valid_o);
    end
    step();
    checks++;
    if (calc_valid_o !== 1'b1 || ack_o !== 4'b0001 || calc_abs2_o !== 16'd3176 ||
        calc_target_o !== 16'd4096 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_issue got cv=%b ack=%b abs=%0d tgt=%0d busy=%b want 1 0001 3176 4096 1",
               calc_valid_o, ack_o, calc_abs2_o, calc_target_o, busy_o);
    end
    step();
    checks++;
    if (calc_valid_o !== 1'b0 || ack_o !== 4'b0000 || calc_abs2_o !== 16'd3176) begin
      errors++;
      $display("FAIL single_pulse got cv=%b ack=%b abs=%0d want 0 0000 3176",
               calc_valid_o, ack_o, calc_abs2_o);
    end
    respond(32'sd920, 2);
    checks++;
    if (eps_valid_o !== 1'b1 || eps_o !== 32'sd920 || eps_ch_o !== 3'd0) begin
      errors++;
      $display("FAIL single_result got v=%b eps=%0d ch=%0d want 1 920 0", eps_valid_o, eps_o, eps_ch_o);
    end
    step();
    checks++;
    if (eps_valid_o !== 1'b0 || eps_o !== 32'sd920 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_after got v=%b eps=%0d busy=%b want 0 920 0", eps_valid_o, eps_o, busy_o);
    end
  endtask

  task automatic test_fairness();
    int order [6] = '{0, 1, 2, 3, 0, 3};
    int abs_v [6] = '{100, 200, 300, 400, 500, 600};
    bit ok;
    apply_reset();
    req_i  = 4'b1111;
    abs2_i = {16'd400, 16'd300, 16'd200, 16'd100};
    step();
    req_i = '0;
    for (int op = 0; op < 6; op++) begin
      if (op == 4) begin
        req_i = 4'b1001;
        abs2_i[15:0]  = 16'd500;
        abs2_i[63:48] = 16'd600;
        step();
        req_i = '0;
      end
      wait_issue(ok);
      checks++;
      if (!ok || ack_o !== 4'(1 << order[op]) || calc_abs2_o !== 16'(abs_v[op])) begin
        errors++;
        $display("FAIL fair_issue%0d got ok=%b ack=%b abs=%0d want ack=%b abs=%0d",
                 op, ok, ack_o, calc_abs2_o, 4'(1 << order[op]), abs_v[op]);
      end
      respond(32'(1000 + op), 1);
      checks++;
      if (eps_valid_o !== 1'b1 || eps_ch_o !== 3'(order[op]) || eps_o !== 32'(1000 + op)) begin
        errors++;
        $display("FAIL fair_result%0d got v=%b ch=%0d eps=%0d want 1 %0d %0d",
                 op, eps_valid_o, eps_ch_o, eps_o, order[op], 1000 + op);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    apply_reset();
    req_i = 4'b0010; abs2_i[31:16] = 16'd10;
    step();
    req_i = '0;
    wait_issue(ok);
    step();
    req_i = 4'b0100; abs2_i[47:32] = 16'd50;
    step();
    abs2_i[47:32] = 16'd70;
    step();
    req_i = '0;
    checks++;
    if (overrun_o !== 4'b0100) begin
      errors++; $display("FAIL overrun_flag got %b want 0100", overrun_o);
    end
    respond(32'sd2000, 0);
    checks++;
    if (eps_valid_o !== 1'b1 || eps_ch_o !== 3'd1) begin
      errors++; $display("FAIL overrun_ch1 got v=%b ch=%0d want 1 1", eps_valid_o, eps_ch_o);
    end
    wait_issue(ok);
    checks++;
    if (!ok || ack_o !== 4'b0100 || calc_abs2_o !== 16'd70) begin
      errors++;
      $display("FAIL overrun_latest got ok=%b ack=%b abs=%0d want 0100 70", ok, ack_o, calc_abs2_o);
    end
    respond(32'sd2001, 1);
    checks++;
    if (eps_ch_o !== 3'd2 || eps_o !== 32'sd2001 || overrun_o !== 4'b0100) begin
      errors++;
      $display("FAIL overrun_done got ch=%0d eps=%0d ovr=%b want 2 2001 0100",
               eps_ch_o, eps_o, overrun_o);
    end
  endtask

  task automatic test_grant_cycle();
    bit ok;
    apply_reset();
    req_i = 4'b0100; abs2_i[47:32] = 16'd5;
    step();
    abs2_i[47:32] = 16'd6;
    step();
    req_i = '0;
    checks++;
    if (calc_valid_o !== 1'b1 || calc_abs2_o !== 16'd5 || overrun_o !== 4'b0000) begin
      errors++;
      $display("FAIL grantcyc_issue got cv=%b abs=%0d ovr=%b want 1 5 0000",
               calc_valid_o, calc_abs2_o, overrun_o);
    end
    respond(32'sd3000, 1);
    wait_issue(ok);
    checks++;
    if (!ok || ack_o !== 4'b0100 || calc_abs2_o !== 16'd6 || overrun_o !== 4'b0000) begin
      errors++;
      $display("FAIL grantcyc_repend got ok=%b ack=%b abs=%0d ovr=%b want 0100 6 0000",
               ok, ack_o, calc_abs2_o, overrun_o);
    end
    respond(32'sd3001, 1);
  endtask

  task automatic test_timeout();
    bit ok;
    bit saw;
    apply_reset();
    req_i = 4'b0011; abs2_i[15:0] = 16'd11; abs2_i[31:16] = 16'd22;
    step();
    req_i = '0;
    wait_issue(ok);
    saw = 1'b0;
    for (int i = 0; i < int'(Tmo); i++) begin
      step();
      if (eps_valid_o) saw = 1'b1;
    end
    checks++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL timeout_early got to=%b busy=%b want 0 1", timeout_o, busy_o);
    end
    step();
    checks++;
    if (timeout_o !== 1'b1 || busy_o !== 1'b0 || saw || eps_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire got to=%b busy=%b saw=%b v=%b want 1 0 0 0",
               timeout_o, busy_o, saw, eps_valid_o);
    end
    wait_issue(ok);
    checks++;
    if (!ok || ack_o !== 4'b0010 || calc_abs2_o !== 16'd22) begin
      errors++;
      $display("FAIL timeout_next got ok=%b ack=%b abs=%0d want 0010 22", ok, ack_o, calc_abs2_o);
    end
    respond(32'sd4000, 1);
    checks++;
    if (eps_valid_o !== 1'b1 || eps_ch_o !== 3'd1 || eps_o !== 32'sd4000 || timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_serve got v=%b ch=%0d eps=%0d to=%b want 1 1 4000 1",
               eps_valid_o, eps_ch_o, eps_o, timeout_o);
    end
  endtask

  task automatic test_cfg_spurious();
    bit ok;
    apply_reset();
    req_i = 4'b0010; abs2_i[31:16] = 16'd33;
    step();
    req_i = '0;
    wait_issue(ok);
    step();
    cfg_we_i = 1'b1; cfg_ch_i = 3'd1; cfg_target_i = 16'd2048;
    step();
    cfg_ch_i = 3'd5; cfg_target_i = 16'd1;
    step();
    cfg_we_i = 1'b0;
    checks++;
    if (calc_target_o !== 16'd4096) begin
      errors++; $display("FAIL cfg_inflight got %0d want 4096", calc_target_o);
    end
    respond(32'sd5000, 0);
    step();
    calc_eps_i = 32'sd777; calc_valid_i = 1'b1;
    step();
    calc_valid_i = 1'b0;
    checks++;
    if (eps_valid_o !== 1'b0 || eps_o !== 32'sd5000 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_idle got v=%b eps=%0d busy=%b want 0 5000 0", eps_valid_o, eps_o, busy_o);
    end
    req_i = 4'b0010; abs2_i[31:16] = 16'd44;
    step();
    req_i = '0;
    wait_issue(ok);
    checks++;
    if (!ok || calc_target_o !== 16'd2048 || calc_abs2_o !== 16'd44) begin
      errors++;
      $display("FAIL cfg_next got ok=%b tgt=%0d abs=%0d want 2048 44", ok, calc_target_o, calc_abs2_o);
    end
    respond(32'sd5001, 1);
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    req_i = 4'b0001; abs2_i[15:0] = 16'd55;
    step();
    req_i = '0;
    wait_issue(ok);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({calc_abs2_o, calc_target_o, calc_valid_o, eps_o, eps_ch_o, eps_valid_o, ack_o,
         busy_o, overrun_o, timeout_o} !== '0) begin
      errors++;
      $display("FAIL rstwait_outputs got busy=%b eps=%0d abs=%0d want all zero", busy_o, eps_o, calc_abs2_o);
    end
    calc_eps_i = 32'sd555; calc_valid_i = 1'b1;
    step();
    calc_valid_i = 1'b0;
    step();
    checks++;
    if (eps_valid_o !== 1'b0 || eps_o !== 32'sd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_late got v=%b eps=%0d busy=%b want 0 0 0", eps_valid_o, eps_o, busy_o);
    end
    req_i = 4'b0010; abs2_i[31:16] = 16'd66;
    step();
    req_i = '0;
    wait_issue(ok);
    checks++;
    if (!ok || calc_target_o !== 16'd4096) begin
      errors++; $display("FAIL rstwait_target got ok=%b tgt=%0d want 4096", ok, calc_target_o);
    end
    respond(32'sd6000, 1);
    checks++;
    if (eps_valid_o !== 1'b1 || eps_ch_o !== 3'd1 || eps_o !== 32'sd6000) begin
      errors++;
      $display("FAIL rstwait_serve got v=%b ch=%0d eps=%0d want 1 1 6000", eps_valid_o, eps_ch_o, eps_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_overrun();
    test_grant_cycle();
    test_timeout();
    test_cfg_spurious();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
